// File: rtl/mem_responder_pkg.sv
// Shared types for the memory responder: FSM states, data word and byte-lane mask.
package mem_responder_pkg;

    localparam int WORD_BYTES = 2;

    typedef logic [8*WORD_BYTES-1:0] word_t;
    typedef logic [WORD_BYTES-1:0]   bmask_t;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

endpackage

// File: rtl/mem_responder_if.sv
// CPU-side memory request/response bundle; the CPU is master, the responder is slave.
interface mem_responder_if;
    import mem_responder_pkg::*;

    logic        read;
    logic        write;
    bmask_t      byte_enable;
    logic [15:0] address;
    word_t       wdata;
    logic        resp;
    word_t       rdata;
    logic        proto_err;

    modport master (
        output read, write, byte_enable, address, wdata,
        input  resp, rdata, proto_err
    );

    modport slave (
        input  read, write, byte_enable, address, wdata,
        output resp, rdata, proto_err
    );

endinterface

// File: rtl/mem_responder_array.sv
// Purpose: 2^ADDR_BITS x 16 RAM with per-byte write enables and registered read port.
// Latency: read data appears the cycle after re; writes land on the same edge.
// Backpressure: none; accepts one access per cycle.
module mem_responder_array
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  bmask_t               we,
    input  logic                 re,
    input  logic [ADDR_BITS-1:0] addr,
    input  word_t                wdata,
    output word_t                rdata
);

    word_t mem [2**ADDR_BITS];

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        for (int b = 0; b < WORD_BYTES; b++) begin
            if (we[b]) begin
                mem[addr][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rdata <= '0;
        end else if (re) begin
            rdata <= mem[addr];
        end
    end

endmodule

// File: rtl/mem_responder.sv
// Purpose: memory-side responder, fixed wait states in front of an internal byte-lane RAM.
// Latency: resp pulses LATENCY cycles after the accepting edge; one transaction per LATENCY+1 cycles.
// Backpressure: initiator holds read/write until resp; dropping it early aborts and flags proto_err.
module mem_responder
    import mem_responder_pkg::*;
#(
    parameter int ADDR_BITS = 8,
    parameter int LATENCY   = 3
) (
    input  logic            clk,
    input  logic            rst_n,
    mem_responder_if.slave  bus
);

    localparam int CNT_W = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CNT_W-1:0] CNT_INIT = CNT_W'(LATENCY - 1);

    state_t                state, next_state;
    logic [CNT_W-1:0]      cnt, cnt_nxt;
    logic                  accept, abort, commit, set_err;
    logic                  perr_q;

    logic                  op_write_q;
    logic [ADDR_BITS-1:0]  waddr_q;
    word_t                 wdata_q;
    bmask_t                be_q;

    logic                  cm_write;
    logic [ADDR_BITS-1:0]  cm_addr;
    word_t                 cm_wdata;
    bmask_t                cm_be;
    bmask_t                arr_we;
    logic                  arr_re;

    logic                  unused_addr_bits;
    assign unused_addr_bits = ^{bus.address[15:ADDR_BITS+1], bus.address[0]};

    always_comb begin
        next_state = state;
        cnt_nxt    = cnt;
        accept     = 1'b0;
        abort      = 1'b0;
        commit     = 1'b0;
        case (state)
            IDLE: begin
                if (bus.read || bus.write) begin
                    accept  = 1'b1;
                    cnt_nxt = CNT_INIT;
                    if (CNT_INIT == '0) begin
                        next_state = RESP;
                        commit     = 1'b1;
                    end else begin
                        next_state = WAIT;
                    end
                end
            end
            WAIT: begin
                // Only the line of the latched operation must stay up.
                if (op_write_q ? !bus.write : !bus.read) begin
                    abort      = 1'b1;
                    next_state = IDLE;
                end else begin
                    cnt_nxt = cnt - CNT_W'(1);
                    if (cnt == CNT_W'(1)) begin
                        next_state = RESP;
                        commit     = 1'b1;
                    end
                end
            end
            RESP:    next_state = IDLE;
            default: next_state = IDLE;
        endcase
    end

    assign set_err = (accept && bus.read && bus.write) || abort;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= IDLE;
            cnt    <= '0;
            perr_q <= 1'b0;
        end else begin
            state <= next_state;
            cnt   <= cnt_nxt;
            if (set_err) begin
                perr_q <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            op_write_q <= bus.write;
            waddr_q    <= bus.address[ADDR_BITS:1];
            wdata_q    <= bus.wdata;
            be_q       <= bus.byte_enable;
        end
    end

    // With LATENCY=1 the commit edge is the accept edge, so the request is used directly.
    always_comb begin
        cm_write = op_write_q;
        cm_addr  = waddr_q;
        cm_wdata = wdata_q;
        cm_be    = be_q;
        if (state == IDLE) begin
            cm_write = bus.write;
            cm_addr  = bus.address[ADDR_BITS:1];
            cm_wdata = bus.wdata;
            cm_be    = bus.byte_enable;
        end
    end

    assign arr_we = (commit && rst_n && cm_write) ? cm_be : '0;
    assign arr_re = commit && rst_n && !cm_write;

    mem_responder_array #(
        .ADDR_BITS (ADDR_BITS)
    ) u_array (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (arr_we),
        .re    (arr_re),
        .addr  (cm_addr),
        .wdata (cm_wdata),
        .rdata (bus.rdata)
    );

    assign bus.resp      = (state == RESP);
    assign bus.proto_err = perr_q;

endmodule
